// File: rtl/calc_serializer.sv
// Parallel-to-serial framer for the calc aggregator's calc_in line.
// A one-word hold register decouples the ALU handshake from frames: start bit 1, then data MSB-first.
module calc_serializer #(
  parameter int alu_width  = 12,
  parameter int cnt_width  = 4,
  parameter int gap_cycles = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 calc_en,
  input  logic [alu_width-1:0] alu_in,
  input  logic                 alu_in_valid,
  output logic                 alu_in_ready,
  output logic                 calc_out,
  output logic                 calc_out_valid,
  output logic                 calc_frame_done,
  output logic                 busy
);
  localparam int                   GAP_W    = (gap_cycles > 1) ? $clog2(gap_cycles) : 1;
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'((gap_cycles > 0) ? gap_cycles - 1 : 0);
  localparam logic [cnt_width-1:0] CNT_LAST = cnt_width'(alu_width - 1);
  localparam bit                   HAS_GAP  = (gap_cycles > 0);

  typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;
  state_t state, state_nxt;

  logic [alu_width-1:0] hold_q, shift_q;
  logic                 hold_full;
  logic [cnt_width-1:0] cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 done_q;
  logic                 accept, drain, last_bit, gap_end;

  assign accept   = alu_in_valid & ~hold_full;
  assign last_bit = (state == DATA) && (cnt == '0);
  assign gap_end  = (state == GAP) && (gap_cnt == '0);
  // Hold drains whenever the FSM is about to enter START; accept and drain are
  // mutually exclusive since one needs hold empty and the other hold full.
  assign drain    = calc_en & hold_full & ((state == IDLE) | gap_end | (last_bit & ~HAS_GAP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          state <= IDLE;
    else if (calc_en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hold_full) state_nxt = START;
      START:   state_nxt = DATA;
      DATA:    if (cnt == '0) state_nxt = HAS_GAP ? GAP : (hold_full ? START : IDLE);
      GAP:     if (gap_cnt == '0) state_nxt = hold_full ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
      shift_q   <= '0;
      cnt       <= '0;
      gap_cnt   <= '0;
      done_q    <= 1'b0;
    end else begin
      if (accept) begin
        hold_q    <= alu_in;
        hold_full <= 1'b1;
      end else if (drain) begin
        hold_full <= 1'b0;
      end
      if (drain)                          shift_q <= hold_q;
      else if (calc_en && state == DATA)  shift_q <= shift_q << 1;
      // cnt reloads only in START and stops at zero, so it can never wrap
      if (calc_en && state == START)                    cnt <= CNT_LAST;
      else if (calc_en && state == DATA && cnt != '0)   cnt <= cnt - 1'b1;
      if (calc_en && last_bit)                          gap_cnt <= GAP_LAST;
      else if (calc_en && state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      done_q <= calc_en & last_bit;
    end
  end

  always_comb begin
    calc_out       = 1'b0;
    calc_out_valid = 1'b0;
    case (state)
      START: begin
        calc_out       = 1'b1;
        calc_out_valid = 1'b1;
      end
      DATA: begin
        calc_out       = shift_q[alu_width-1];
        calc_out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_in_ready    = ~hold_full;
  assign calc_frame_done = done_q;
  assign busy            = (state != IDLE) | hold_full;

endmodule

// File: tb/tb_calc_serializer.sv
// Bench for calc_serializer: gap_cycles=1 instance plus a gap_cycles=0 twin on shared stimulus.
// A negedge monitor assembles frames into rx queues; tasks compare them against expected queues.
module tb_calc_serializer;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst, calc_en, alu_in_valid;
  logic [W-1:0] alu_in;
  logic         ready1, out1, ov1, done1, busy1;
  logic         ready0, out0, ov0, done0, busy0;

  int n_cmp = 0, n_err = 0;
  logic [W:0] expq1[$], expq0[$], rxq1[$], rxq0[$];

  always #5 clk = ~clk;

  calc_serializer #(.alu_width(W), .cnt_width(4), .gap_cycles(1)) dut (
    .clk(clk), .rst(rst), .calc_en(calc_en), .alu_in(alu_in), .alu_in_valid(alu_in_valid),
    .alu_in_ready(ready1), .calc_out(out1), .calc_out_valid(ov1), .calc_frame_done(done1), .busy(busy1));

  calc_serializer #(.alu_width(W), .cnt_width(4), .gap_cycles(0)) dut0 (
    .clk(clk), .rst(rst), .calc_en(calc_en), .alu_in(alu_in), .alu_in_valid(alu_in_valid),
    .alu_in_ready(ready0), .calc_out(out0), .calc_out_valid(ov0), .calc_frame_done(done0), .busy(busy0));

  // Frame monitor: a line bit is new only if the edge that produced it was not stalled.
  logic       en_last;
  int         bi1 = 0, bi0 = 0;
  logic [W:0] sh1 = '0, sh0 = '0;
  always @(posedge clk) en_last <= calc_en;
  always @(negedge clk) begin
    if (rst) begin
      bi1 <= 0;
      bi0 <= 0;
    end else begin
      if (ov1 && en_last) begin
        if (bi1 == W) begin rxq1.push_back({sh1[W-1:0], out1}); bi1 <= 0; end
        else begin sh1 <= {sh1[W-1:0], out1}; bi1 <= bi1 + 1; end
      end
      if (ov0 && en_last) begin
        if (bi0 == W) begin rxq0.push_back({sh0[W-1:0], out0}); bi0 <= 0; end
        else begin sh0 <= {sh0[W-1:0], out0}; bi0 <= bi0 + 1; end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    bit ok = 1'b0;
    alu_in       = w;
    alu_in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      ok = (ready1 === 1'b1);
      tick();
    end
    alu_in_valid = 1'b0;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL send_accept: ready=%b never high, word %h", ready1, w); end
    else begin expq1.push_back({1'b1, w}); expq0.push_back({1'b1, w}); end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy1 && !busy0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; calc_en = 1'b1; alu_in_valid = 1'b0; alu_in = '0;
    repeat (2) tick();
    n_cmp++;
    if ({out1, ov1, done1, busy1, ready1} !== 5'b00001) begin
      n_err++; $display("FAIL reset_out: got %b want 00001", {out1, ov1, done1, busy1, ready1});
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({out1, ov1, done1, busy1, ready1} !== 5'b00001) begin
        n_err++; $display("FAIL reset_idle: cycle %0d got %b want 00001", i, {out1, ov1, done1, busy1, ready1});
      end
    end
  endtask

  task automatic test_single();
    logic [W-1:0] w = 12'hA5C;
    logic [W:0]   e, r;
    bit           ok;
    send(w);
    n_cmp++;
    if ({ov1, ready1, busy1} !== 3'b001) begin n_err++; $display("FAIL single_held: got %b want 001", {ov1, ready1, busy1}); end
    tick();
    n_cmp++;
    if ({out1, ov1} !== 2'b11) begin n_err++; $display("FAIL single_start: got %b want 11", {out1, ov1}); end
    for (int k = 0; k < W; k++) begin
      tick();
      n_cmp++;
      if ({out1, ov1} !== {w[W-1-k], 1'b1}) begin
        n_err++; $display("FAIL single_bit%0d: got %b want %b", k, {out1, ov1}, {w[W-1-k], 1'b1});
      end
    end
    tick();
    n_cmp++;
    if ({ov1, done1} !== 2'b01) begin n_err++; $display("FAIL single_done: got %b want 01", {ov1, done1}); end
    tick();
    n_cmp++;
    if (done1 !== 1'b0) begin n_err++; $display("FAIL single_done_width: got %b want 0", done1); end
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL single_idle: busy=%b want 0", busy1); end
    while (expq1.size() > 0) begin
      e = expq1.pop_front();
      n_cmp++;
      if (rxq1.size() == 0) begin n_err++; $display("FAIL single_sb: no frame, want %h", e); end
      else begin r = rxq1.pop_front(); if (r !== e) begin n_err++; $display("FAIL single_sb: got %h want %h", r, e); end end
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] e, r;
    bit         ok;
    expq0.delete(); rxq0.delete();
    alu_in = 12'hFFF; alu_in_valid = 1'b1;
    tick();                                           // edge N: FFF accepted
    expq1.push_back({1'b1, 12'hFFF}); expq0.push_back({1'b1, 12'hFFF});
    alu_in = 12'h001;
    n_cmp++;
    if (ready1 !== 1'b0) begin n_err++; $display("FAIL b2b_ready_full: got %b want 0", ready1); end
    tick();                                           // N+1: start bit, hold empty again
    n_cmp++;
    if ({ready1, out1, ov1} !== 3'b111) begin n_err++; $display("FAIL b2b_start1: got %b want 111", {ready1, out1, ov1}); end
    tick();                                           // N+2: 001 accepted
    expq1.push_back({1'b1, 12'h001}); expq0.push_back({1'b1, 12'h001});
    alu_in_valid = 1'b0;
    n_cmp++;
    if ({ready1, busy1} !== 2'b01) begin n_err++; $display("FAIL b2b_second_held: got %b want 01", {ready1, busy1}); end
    repeat (11) tick();                               // N+13: last bit of FFF
    n_cmp++;
    if ({out1, ov1, out0, ov0} !== 4'b1111) begin n_err++; $display("FAIL b2b_lastbit: got %b want 1111", {out1, ov1, out0, ov0}); end
    tick();                                           // N+14
    n_cmp++;
    if ({ov1, done1} !== 2'b01) begin n_err++; $display("FAIL b2b_gap1: got %b want 01", {ov1, done1}); end
    n_cmp++;
    if ({ov0, out0, done0} !== 3'b111) begin n_err++; $display("FAIL b2b_gap0_start: got %b want 111", {ov0, out0, done0}); end
    tick();                                           // N+15
    n_cmp++;
    if ({ov1, out1, done1} !== 3'b110) begin n_err++; $display("FAIL b2b_start2: got %b want 110", {ov1, out1, done1}); end
    n_cmp++;
    if ({ov0, out0, done0} !== 3'b100) begin n_err++; $display("FAIL b2b_gap0_msb: got %b want 100", {ov0, out0, done0}); end
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL b2b_idle: busy=%b%b want 00", busy1, busy0); end
    while (expq1.size() > 0) begin
      e = expq1.pop_front();
      n_cmp++;
      if (rxq1.size() == 0) begin n_err++; $display("FAIL b2b_sb: no frame, want %h", e); end
      else begin r = rxq1.pop_front(); if (r !== e) begin n_err++; $display("FAIL b2b_sb: got %h want %h", r, e); end end
    end
    while (expq0.size() > 0) begin
      e = expq0.pop_front();
      n_cmp++;
      if (rxq0.size() == 0) begin n_err++; $display("FAIL b2b_sb_gap0: no frame, want %h", e); end
      else begin r = rxq0.pop_front(); if (r !== e) begin n_err++; $display("FAIL b2b_sb_gap0: got %h want %h", r, e); end end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] w = 12'h3C3;
    logic [W:0]   e, r;
    int           t = 0, vc = 0;
    bit           done_seen = 1'b0, ok;
    send(w);
    for (int i = 0; i < 7; i++) begin tick(); t++; if (ov1) vc++; end   // bit 5 on the line
    n_cmp++;
    if ({out1, ov1} !== {w[W-1-5], 1'b1}) begin n_err++; $display("FAIL stall_bit5: got %b want %b", {out1, ov1}, {w[W-1-5], 1'b1}); end
    calc_en = 1'b0; alu_in = 12'h5A5; alu_in_valid = 1'b1;
    tick(); t++; if (ov1) vc++; done_seen |= done1;
    alu_in_valid = 1'b0;
    expq1.push_back({1'b1, 12'h5A5}); expq0.push_back({1'b1, 12'h5A5});
    n_cmp++;
    if (ready1 !== 1'b0) begin n_err++; $display("FAIL stall_handshake: ready=%b want 0", ready1); end
    repeat (2) begin tick(); t++; if (ov1) vc++; done_seen |= done1; end
    n_cmp++;
    if ({out1, ov1, done_seen} !== {w[W-1-5], 2'b10}) begin
      n_err++; $display("FAIL stall_hold: got %b want %b", {out1, ov1, done_seen}, {w[W-1-5], 2'b10});
    end
    calc_en = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); t++; if (ov1) vc++; else break; end
    n_cmp++;
    if ({done1, vc, t} !== {1'b1, 32'd16, 32'd17}) begin
      n_err++; $display("FAIL stall_frame: done=%b valid_cycles=%0d done_edge=%0d want 1/16/17", done1, vc, t);
    end
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL stall_idle: busy=%b want 0", busy1); end
    while (expq1.size() > 0) begin
      e = expq1.pop_front();
      n_cmp++;
      if (rxq1.size() == 0) begin n_err++; $display("FAIL stall_sb: no frame, want %h", e); end
      else begin r = rxq1.pop_front(); if (r !== e) begin n_err++; $display("FAIL stall_sb: got %h want %h", r, e); end end
    end
  endtask

  task automatic test_reset_midframe();
    logic [W:0] e, r;
    int         dones = 0;
    bit         ok;
    send(12'h7FF);
    send(12'h0F0);
    repeat (7) tick();                                // bit 7 of 7FF on the line
    n_cmp++;
    if ({out1, ov1, ready1} !== 3'b110) begin n_err++; $display("FAIL midrst_pre: got %b want 110", {out1, ov1, ready1}); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out1, ov1, done1, busy1, ready1} !== 5'b00001) begin
      n_err++; $display("FAIL midrst_async: got %b want 00001", {out1, ov1, done1, busy1, ready1});
    end
    expq1.delete(); expq0.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); dones += int'(done1); end
    n_cmp++;
    if ({dones, ov1} !== {32'd0, 1'b0}) begin n_err++; $display("FAIL midrst_quiet: dones=%0d valid=%b want 0/0", dones, ov1); end
    send(12'h123);
    for (int i = 0; i < 40 && busy1; i++) begin tick(); dones += int'(done1); end
    wait_idle(ok);
    n_cmp++;
    if (!ok || dones != 1) begin n_err++; $display("FAIL midrst_after: idle=%b dones=%0d want 1/1", ok, dones); end
    while (expq1.size() > 0) begin
      e = expq1.pop_front();
      n_cmp++;
      if (rxq1.size() == 0) begin n_err++; $display("FAIL midrst_sb: no frame, want %h", e); end
      else begin r = rxq1.pop_front(); if (r !== e) begin n_err++; $display("FAIL midrst_sb: got %h want %h", r, e); end end
    end
    n_cmp++;
    if (rxq1.size() != 0) begin n_err++; $display("FAIL midrst_stray: %0d extra frames want 0", rxq1.size()); end
  endtask

  task automatic test_zero();
    logic [W:0] e, r;
    int         vc = 0;
    bit         ok;
    send('0);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!ov1) break;
      vc++;
      n_cmp++;
      if (out1 !== (vc == 1)) begin n_err++; $display("FAIL zero_bit%0d: got %b want %b", vc - 1, out1, vc == 1); end
    end
    n_cmp++;
    if ({done1, vc} !== {1'b1, 32'd13}) begin n_err++; $display("FAIL zero_frame: done=%b valid_cycles=%0d want 1/13", done1, vc); end
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL zero_idle: busy=%b want 0", busy1); end
    while (expq1.size() > 0) begin
      e = expq1.pop_front();
      n_cmp++;
      if (rxq1.size() == 0) begin n_err++; $display("FAIL zero_sb: no frame, want %h", e); end
      else begin r = rxq1.pop_front(); if (r !== e) begin n_err++; $display("FAIL zero_sb: got %h want %h", r, e); end end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_midframe();
    test_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
